// File: rtl/player_pkg.sv
// Shared definitions for the player movement controller.
//   - Direction codes as seen on world_btns (U=8, D=4, R=2, L=1, none=0).
//   - btn_raw bit positions.
//   - Default screen/player geometry.
//   - FSM state type and the U>D>R>L direction priority function.
package player_pkg;

    localparam logic [3:0] DIR_NONE = 4'd0;
    localparam logic [3:0] DIR_U    = 4'd8;
    localparam logic [3:0] DIR_D    = 4'd4;
    localparam logic [3:0] DIR_R    = 4'd2;
    localparam logic [3:0] DIR_L    = 4'd1;

    // btn_raw bit positions: {C,U,D,R,L}
    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_D = 2;
    localparam int unsigned BTN_U = 3;
    localparam int unsigned BTN_C = 4;

    localparam int unsigned SCR_W_DEF = 640;
    localparam int unsigned SCR_H_DEF = 480;
    localparam int unsigned P_W_DEF   = 12;
    localparam int unsigned P_H_DEF   = 12;

    typedef enum logic {
        IDLE,
        MOVE
    } state_t;

    // Priority select on {U,D,R,L}; at most one direction code is returned.
    function automatic logic [3:0] dir_select(input logic [3:0] udrl);
        if (udrl[3])      return DIR_U;
        else if (udrl[2]) return DIR_D;
        else if (udrl[1]) return DIR_R;
        else if (udrl[0]) return DIR_L;
        else              return DIR_NONE;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for one asynchronous button plus a rising-edge pulse.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   i_async  in  raw button level (asynchronous)
//   o_sync   out synchronised level
//   o_rise   out one-cycle pulse on the 0->1 transition of o_sync
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/player_ctrl.sv
// Player movement controller.
// Synchronises the five buttons, picks one direction (U>D>R>L), paces repeated
// steps with a divider, refuses steps blocked by any Rectangle, clamps to the
// screen, and cycles the player colour on each C press.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   btn_raw[4:0]        raw buttons {C,U,D,R,L}
//   up/down/left/right_dis[N_RECT-1:0]  per-Rectangle block flags
//   player_hPos/vPos    player left/top edge (px)
//   player_color        current colour index
//   world_btns          direction code of last accepted step (0 after idle)
//   world_step          one-cycle pulse per accepted step
//   blocked             one-cycle pulse per refused step
module player_ctrl
    import player_pkg::*;
#(
    parameter int unsigned N_RECT   = 4,
    parameter int unsigned SCR_W    = SCR_W_DEF,
    parameter int unsigned SCR_H    = SCR_H_DEF,
    parameter int unsigned P_W      = P_W_DEF,
    parameter int unsigned P_H      = P_H_DEF,
    parameter int unsigned START_H  = 314,
    parameter int unsigned START_V  = 234,
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned N_COLORS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        btn_raw,
    input  logic [N_RECT-1:0] up_dis,
    input  logic [N_RECT-1:0] down_dis,
    input  logic [N_RECT-1:0] left_dis,
    input  logic [N_RECT-1:0] right_dis,
    output logic [11:0]       player_hPos,
    output logic [11:0]       player_vPos,
    output logic [3:0]        player_color,
    output logic [3:0]        world_btns,
    output logic              world_step,
    output logic              blocked
);

    localparam int unsigned DIV_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [11:0] H_MAX    = 12'(SCR_W - P_W);
    localparam logic [11:0] V_MAX    = 12'(SCR_H - P_H);
    localparam logic [11:0] H_START  = 12'(START_H);
    localparam logic [11:0] V_START  = 12'(START_V);
    localparam logic [3:0]  COL_LAST = 4'(N_COLORS - 1);

    logic [4:0] w_sync;
    logic [3:0] w_dir_rise_unused;
    logic       w_c_rise;
    logic [3:0] w_dir;
    logic       w_blk;
    logic       w_take_step;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [11:0]      r_hpos;
    logic [11:0]      r_vpos;
    logic [3:0]       r_color;
    logic [3:0]       r_btns;
    logic             r_step;
    logic             r_blocked;

    // Direction buttons only need their level; only C uses the edge pulse.
    for (genvar g = 0; g < 4; g++) begin : g_dir_sync
        btn_sync_edge u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_async (btn_raw[g]),
            .o_sync  (w_sync[g]),
            .o_rise  (w_dir_rise_unused[g])
        );
    end

    btn_sync_edge u_sync_c (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (btn_raw[BTN_C]),
        .o_sync  (w_sync[BTN_C]),
        .o_rise  (w_c_rise)
    );

    assign w_dir = dir_select(w_sync[BTN_U:BTN_L]);

    always_comb begin
        w_blk = 1'b0;
        unique case (w_dir)
            DIR_U:   w_blk = |up_dis;
            DIR_D:   w_blk = |down_dis;
            DIR_R:   w_blk = |right_dis;
            DIR_L:   w_blk = |left_dis;
            default: w_blk = 1'b0;
        endcase
    end

    // First step is immediate on press; further steps fire when the divider wraps.
    always_comb begin
        w_take_step = 1'b0;
        if (w_dir != DIR_NONE) begin
            if (r_state == IDLE) w_take_step = 1'b1;
            else                 w_take_step = (r_div == DIV_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_hpos    <= H_START;
            r_vpos    <= V_START;
            r_color   <= '0;
            r_btns    <= DIR_NONE;
            r_step    <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_step    <= 1'b0;
            r_blocked <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    r_div <= '0;
                    if (w_dir != DIR_NONE) r_state <= MOVE;
                end
                MOVE: begin
                    if (w_dir == DIR_NONE) begin
                        r_state <= IDLE;
                        r_div   <= '0;
                        r_btns  <= DIR_NONE;
                    end else if (r_div == DIV_LAST) begin
                        r_div <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Edge compare precedes the +/-1 so the position never wraps;
            // a clamped step still reports world_step for scrolling.
            if (w_take_step) begin
                if (w_blk) begin
                    r_blocked <= 1'b1;
                end else begin
                    r_step <= 1'b1;
                    r_btns <= w_dir;
                    unique case (w_dir)
                        DIR_U:   if (r_vpos != 12'd0) r_vpos <= r_vpos - 12'd1;
                        DIR_D:   if (r_vpos != V_MAX) r_vpos <= r_vpos + 12'd1;
                        DIR_R:   if (r_hpos != H_MAX) r_hpos <= r_hpos + 12'd1;
                        DIR_L:   if (r_hpos != 12'd0) r_hpos <= r_hpos - 12'd1;
                        default: ;
                    endcase
                end
            end

            if (w_c_rise) begin
                r_color <= (r_color == COL_LAST) ? 4'd0 : r_color + 4'd1;
            end
        end
    end

    assign player_hPos  = r_hpos;
    assign player_vPos  = r_vpos;
    assign player_color = r_color;
    assign world_btns   = r_btns;
    assign world_step   = r_step;
    assign blocked      = r_blocked;

endmodule

// File: tb/tb_player_ctrl.sv
module tb_player_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  btn_raw;
    logic [3:0]  up_dis, down_dis, left_dis, right_dis;
    logic [11:0] player_hPos, player_vPos;
    logic [3:0]  player_color, world_btns;
    logic        world_step, blocked;

    player_ctrl #(
        .N_RECT   (4),
        .SCR_W    (640),
        .SCR_H    (480),
        .P_W      (12),
        .P_H      (12),
        .START_H  (314),
        .START_V  (234),
        .STEP_DIV (4),
        .N_COLORS (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .up_dis       (up_dis),
        .down_dis     (down_dis),
        .left_dis     (left_dis),
        .right_dis    (right_dis),
        .player_hPos  (player_hPos),
        .player_vPos  (player_vPos),
        .player_color (player_color),
        .world_btns   (world_btns),
        .world_step   (world_step),
        .blocked      (blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        blk;
        logic [11:0] h;
        logic [11:0] v;
        logic [3:0]  btns;
    } ev_t;

    ev_t q[$];

    int vectors    = 0;
    int miscompares = 0;
    int n_events   = 0;
    int cyc        = 0;

    // Reference state of the player as seen by the bench
    logic [11:0] exp_h    = 12'd314;
    logic [11:0] exp_v    = 12'd234;
    logic [3:0]  exp_btns = 4'd0;
    logic [3:0]  exp_col  = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every step/blocked pulse must match the next expected event
    always @(negedge clk) begin
        if (rst_n) begin
            if (world_step && blocked) begin
                vectors++;
                miscompares++;
                $display("FAIL step_blocked_overlap cyc=%0d got both=1 required exclusive", cyc);
            end
            if (world_step || blocked) begin
                n_events++;
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event cyc=%0d step=%b blocked=%b h=%0d v=%0d required none",
                             cyc, world_step, blocked, player_hPos, player_vPos);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (cyc !== e.cyc || blocked !== e.blk || player_hPos !== e.h ||
                        player_vPos !== e.v || world_btns !== e.btns) begin
                        miscompares++;
                        $display("FAIL step_event got cyc=%0d blk=%b h=%0d v=%0d btns=%0d required cyc=%0d blk=%b h=%0d v=%0d btns=%0d",
                                 cyc, blocked, player_hPos, player_vPos, world_btns,
                                 e.cyc, e.blk, e.h, e.v, e.btns);
                    end
                end
            end
        end
    end

    function automatic logic [3:0] dir_of(input logic [4:0] b);
        if (b[3])      return 4'd8;
        else if (b[2]) return 4'd4;
        else if (b[1]) return 4'd2;
        else if (b[0]) return 4'd1;
        else           return 4'd0;
    endfunction

    // Press buttons b at a negedge, hold for 'hold' cycles, release, then settle.
    // Block flags are cleared at offset clr_off (negative = never).
    task automatic press_hold(input logic [4:0] b, input int hold, input int clr_off, input string name);
        logic [3:0] d;
        logic       blk;
        int         c;
        ev_t        e;
        d = dir_of(b);
        c = cyc;
        btn_raw = b;
        if (b[4]) exp_col = (exp_col == 4'd3) ? 4'd0 : exp_col + 4'd1;
        if (d != 4'd0) begin
            for (int k = 0; 4 * k <= hold - 1; k++) begin
                int t;
                t = 3 + 4 * k;
                if (clr_off >= 0 && t > clr_off) blk = 1'b0;
                else begin
                    case (d)
                        4'd8:    blk = |up_dis;
                        4'd4:    blk = |down_dis;
                        4'd2:    blk = |right_dis;
                        default: blk = |left_dis;
                    endcase
                end
                if (!blk) begin
                    case (d)
                        4'd8:    if (exp_v != 12'd0)   exp_v = exp_v - 12'd1;
                        4'd4:    if (exp_v != 12'd468) exp_v = exp_v + 12'd1;
                        4'd2:    if (exp_h != 12'd628) exp_h = exp_h + 12'd1;
                        default: if (exp_h != 12'd0)   exp_h = exp_h - 12'd1;
                    endcase
                    exp_btns = d;
                end
                e.cyc = c + t; e.blk = blk; e.h = exp_h; e.v = exp_v; e.btns = exp_btns;
                q.push_back(e);
            end
        end
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (i == clr_off) begin
                up_dis = '0; down_dis = '0; left_dis = '0; right_dis = '0;
            end
        end
        btn_raw = '0;
        exp_btns = 4'd0;
        repeat (8) @(negedge clk);
        vectors++;
        if (q.size() !== 0) begin
            miscompares++;
            $display("FAIL %s missing_events got %0d pending required 0", name, q.size());
            q.delete();
        end
        vectors++;
        if (player_hPos !== exp_h) begin
            miscompares++;
            $display("FAIL %s hPos got %0d required %0d", name, player_hPos, exp_h);
        end
        vectors++;
        if (player_vPos !== exp_v) begin
            miscompares++;
            $display("FAIL %s vPos got %0d required %0d", name, player_vPos, exp_v);
        end
        vectors++;
        if (world_btns !== exp_btns) begin
            miscompares++;
            $display("FAIL %s world_btns_idle got %0d required %0d", name, world_btns, exp_btns);
        end
        vectors++;
        if (player_color !== exp_col) begin
            miscompares++;
            $display("FAIL %s color got %0d required %0d", name, player_color, exp_col);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_raw = '0;
        up_dis = '0; down_dis = '0; left_dis = '0; right_dis = '0;
        repeat (3) @(negedge clk);
        vectors++; if (player_hPos !== 12'd314) begin miscompares++; $display("FAIL reset_hPos got %0d required 314", player_hPos); end
        vectors++; if (player_vPos !== 12'd234) begin miscompares++; $display("FAIL reset_vPos got %0d required 234", player_vPos); end
        vectors++; if (player_color !== 4'd0) begin miscompares++; $display("FAIL reset_color got %0d required 0", player_color); end
        vectors++; if (world_btns !== 4'd0) begin miscompares++; $display("FAIL reset_world_btns got %0d required 0", world_btns); end
        vectors++; if (world_step !== 1'b0) begin miscompares++; $display("FAIL reset_world_step got %b required 0", world_step); end
        vectors++; if (blocked !== 1'b0) begin miscompares++; $display("FAIL reset_blocked got %b required 0", blocked); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (n_events !== 0) begin
            miscompares++;
            $display("FAIL idle_no_step got %0d events required 0", n_events);
        end
        vectors++; if (player_vPos !== 12'd234) begin miscompares++; $display("FAIL idle_vPos got %0d required 234", player_vPos); end
    endtask

    task automatic test_hold_up();
        press_hold(5'b01000, 9, -1, "hold_up");
    endtask

    task automatic test_clamp_up();
        press_hold(5'b01000, 4 * 236, -1, "clamp_up");
    endtask

    task automatic test_blocked_down();
        down_dis = 4'b0100;
        up_dis   = 4'b1000;
        press_hold(5'b00100, 17, 9, "blocked_down");
    endtask

    task automatic test_priority();
        press_hold(5'b01010, 9, -1, "priority_u_over_r");
    endtask

    task automatic test_color();
        for (int i = 0; i < 5; i++) press_hold(5'b10000, 4, -1, "color_press");
        press_hold(5'b10100, 5, -1, "color_with_step");
    endtask

    task automatic test_reset_mid_move();
        ev_t e;
        int  c;
        int  ev_before;
        c = cyc;
        btn_raw = 5'b00010;
        exp_h = exp_h + 12'd1;
        e.cyc = c + 3; e.blk = 1'b0; e.h = exp_h; e.v = exp_v; e.btns = 4'd2;
        q.push_back(e);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_h = 12'd314; exp_v = 12'd234; exp_btns = 4'd0; exp_col = 4'd0;
        vectors++; if (player_hPos !== exp_h) begin miscompares++; $display("FAIL async_reset_hPos got %0d required %0d", player_hPos, exp_h); end
        vectors++; if (player_vPos !== exp_v) begin miscompares++; $display("FAIL async_reset_vPos got %0d required %0d", player_vPos, exp_v); end
        vectors++; if (world_btns !== 4'd0) begin miscompares++; $display("FAIL async_reset_btns got %0d required 0", world_btns); end
        vectors++; if (player_color !== 4'd0) begin miscompares++; $display("FAIL async_reset_color got %0d required 0", player_color); end
        vectors++;
        if (q.size() !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_move_first_step got %0d pending required 0", q.size());
            q.delete();
        end
        btn_raw = '0;
        ev_before = n_events;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (n_events !== ev_before) begin
            miscompares++;
            $display("FAIL post_reset_no_step got %0d events required %0d", n_events, ev_before);
        end
        press_hold(5'b00001, 5, -1, "fresh_press_left");
    endtask

    initial begin
        test_reset();
        test_hold_up();
        test_clamp_up();
        test_blocked_down();
        test_priority();
        test_color();
        test_reset_mid_move();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
